// File: rtl/iact_csc_encoder_if.sv
// ---------------------------------------------------------------------------
// iact_csc_encoder_if
// Bundles the two streaming handshakes of the iact CSC encoder:
//   dense activation input : in_valid, in_ready, in_data[DATA_W-1:0]
//   CSC word output        : out_valid, out_ready, out_data[DATA_W+CNT_W-1:0]
// Modports:
//   master : encoder side (accepts the dense stream, drives the CSC stream)
//   slave  : environment side (feeds activations, sinks CSC words / SRAM)
// ---------------------------------------------------------------------------
interface iact_csc_encoder_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) ();
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W-1:0]        in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W+CNT_W-1:0]  out_data;

    modport master (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport slave (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/iact_csc_encoder.sv
// ---------------------------------------------------------------------------
// iact_csc_encoder
// Compresses dense column-major activations into the zero-terminated CSC
// word stream consumed by the GLB iact data SRAM. Each nonzero element
// becomes {data,row}; every column ends with 12'h000 and the whole stream
// ends with an extra 12'h000 (two consecutive zeros = write done). An empty
// column emits the filler word {0,all-ones row} so it never produces two
// adjacent zeros.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-low reset
//   cfg_col_h_m1        column height - 1, latched on start
//   cfg_cols_m1         column count - 1, latched on start
//   start               1-cycle start pulse, accepted only when idle
//   busy                high from accepted start until the stream is done
//   done                1-cycle pulse once the final zero word is taken
//   overflow            sticky, word offset saturated; cleared by start
//   bus (master)        dense input and CSC output handshakes
// Optional feature (macro IACT_CSC_ADDR_OUT_EN):
//   addr_out_valid, addr_out  1-cycle pulse with the word offset of each
//   column's first word, for the consumer's column-pointer table.
// ---------------------------------------------------------------------------
module iact_csc_encoder #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4,
    parameter int IDX_W  = 11
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CNT_W-1:0]  cfg_col_h_m1,
    input  logic [4:0]        cfg_cols_m1,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    iact_csc_encoder_if.master bus
`ifdef IACT_CSC_ADDR_OUT_EN
    ,
    output logic              addr_out_valid,
    output logic [IDX_W-1:0]  addr_out
`endif
);

    typedef enum logic [2:0] {IDLE, RUN, PAD, TERM, FINAL, DRAIN} state_t;

    localparam logic [IDX_W-1:0] WORD_MAX = '1;

    state_t                   state;
    logic [CNT_W-1:0]         col_h_m1;
    logic [4:0]               cols_m1;
    logic [CNT_W-1:0]         row;
    logic [4:0]               col;
    logic [IDX_W-1:0]         word;
    logic                     col_nz;
    logic                     out_valid_q;
    logic [DATA_W+CNT_W-1:0]  out_data_q;

    logic                     adv;
    logic                     take;
    logic                     nz;
    logic                     word_sat;
    logic [IDX_W-1:0]         word_next;

    // The single output register may be refilled when it is empty or being drained.
    assign adv       = !out_valid_q || bus.out_ready;
    assign take      = bus.in_valid && (state == RUN) && adv;
    assign nz        = |bus.in_data;
    assign word_sat  = (word == WORD_MAX);
    assign word_next = word_sat ? word : word + 1'b1;

    assign bus.in_ready  = (state == RUN) && adv;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            col_h_m1    <= '0;
            cols_m1     <= '0;
            row         <= '0;
            col         <= '0;
            word        <= '0;
            col_nz      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef IACT_CSC_ADDR_OUT_EN
            addr_out_valid <= 1'b0;
            addr_out       <= '0;
`endif
        end else begin
            done <= 1'b0;
`ifdef IACT_CSC_ADDR_OUT_EN
            addr_out_valid <= 1'b0;
`endif
            // A handed-off word empties the register unless a new load below refills it.
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        col_h_m1 <= cfg_col_h_m1;
                        cols_m1  <= cfg_cols_m1;
                        row      <= '0;
                        col      <= '0;
                        word     <= '0;
                        col_nz   <= 1'b0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end

                RUN: begin
                    if (take) begin
                        if (nz) begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= {bus.in_data, row};
                            col_nz      <= 1'b1;
                            word        <= word_next;
                            if (word_sat) begin
                                overflow <= 1'b1;
                            end
`ifdef IACT_CSC_ADDR_OUT_EN
                            // First nonzero of the column is the column's first word.
                            if (!col_nz) begin
                                addr_out_valid <= 1'b1;
                                addr_out       <= word;
                            end
`endif
                        end
                        row <= row + 1'b1;
                        if (row == col_h_m1) begin
                            state <= (col_nz || nz) ? TERM : PAD;
                        end
                    end
                end

                PAD: begin
                    if (adv) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= {{DATA_W{1'b0}}, {CNT_W{1'b1}}};
                        word        <= word_next;
                        if (word_sat) begin
                            overflow <= 1'b1;
                        end
`ifdef IACT_CSC_ADDR_OUT_EN
                        addr_out_valid <= 1'b1;
                        addr_out       <= word;
`endif
                        state <= TERM;
                    end
                end

                TERM: begin
                    if (adv) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= '0;
                        word        <= word_next;
                        if (word_sat) begin
                            overflow <= 1'b1;
                        end
                        row    <= '0;
                        col_nz <= 1'b0;
                        if (col == cols_m1) begin
                            state <= FINAL;
                        end else begin
                            col   <= col + 1'b1;
                            state <= RUN;
                        end
                    end
                end

                FINAL: begin
                    if (adv) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= '0;
                        state       <= DRAIN;
                    end
                end

                DRAIN: begin
                    if (out_valid_q && bus.out_ready) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
